// File: rtl/dsp_result_unpacker.sv
// Serializes the 144-bit packed DSP result word onto a 36-bit valid/ready stream.
// Pass-through words go out as 4 beats; accumulate words go out as 2 beats.
module dsp_result_unpacker #(
    parameter bit          ACC_SIGNED = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [143:0]     S,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [35:0]      out_data,
    output logic [1:0]       out_beat,
    output logic             out_last,
    output logic [CNT_W-1:0] words_done
);
    localparam int unsigned IN_W   = 144;
    localparam int unsigned OUT_W  = 36;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned EXT_W  = 28;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [IN_W-1:0]   hold_s;
    logic              hold_mode;
    logic              xfer;
    logic              accept;
    logic [BEAT_W-1:0] next_beat;

    // Beat selection from a held word; accumulate words carry their result in [143:100].
    function automatic logic [OUT_W-1:0] beat_data(input logic [IN_W-1:0]   s,
                                                   input logic              mode,
                                                   input logic [BEAT_W-1:0] idx);
        logic ext;
        ext       = ACC_SIGNED ? s[IN_W-1] : 1'b0;
        beat_data = '0;
        if (mode) begin
            case (idx)
                2'd0:    beat_data = s[35:0];
                2'd1:    beat_data = s[71:36];
                2'd2:    beat_data = s[107:72];
                default: beat_data = s[143:108];
            endcase
        end else if (idx == 2'd0) begin
            beat_data = s[135:100];
        end else begin
            beat_data = {{EXT_W{ext}}, s[143:136]};
        end
    endfunction

    function automatic logic beat_last(input logic mode, input logic [BEAT_W-1:0] idx);
        beat_last = mode ? (idx == 2'd3) : (idx == 2'd1);
    endfunction

    // Last-beat transfer frees the holder in the same cycle for bubble-free streaming.
    assign xfer      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (xfer && out_last);
    assign accept    = in_valid && in_ready;
    assign next_beat = out_beat + BEAT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_s     <= '0;
            hold_mode  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_beat   <= '0;
            out_last   <= 1'b0;
            words_done <= '0;
        end else begin
            if (xfer && !out_last) begin
                out_beat <= next_beat;
                out_data <= beat_data(hold_s, hold_mode, next_beat);
                out_last <= beat_last(hold_mode, next_beat);
            end
            if (xfer && out_last) begin
                words_done <= words_done + CNT_W'(1);
                state      <= IDLE;
                out_valid  <= 1'b0;
            end
            // A new word overrides the return to IDLE when it arrives on the last beat.
            if (accept) begin
                hold_s    <= S;
                hold_mode <= in_mode;
                state     <= SEND;
                out_valid <= 1'b1;
                out_beat  <= '0;
                out_data  <= beat_data(S, in_mode, BEAT_W'(0));
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dsp_result_unpacker.md
Name: dsp_result_unpacker

Overview:
- Drains the 144-bit packed result word produced by the DSP accumulate stage and serializes it onto a 36-bit valid/ready stream for the fabric.
- Decodes the packing by mode:
  - Pass-through words carry {A0[71:0], B0[71:0]}.
  - Accumulate words carry a 44-bit result in bits [143:100]; bits [99:0] are zero.
- Sits directly downstream of the accumulate stage. Holds one word and emits it as 4 beats (pass-through) or 2 beats (accumulate).

Parameters:
- ACC_SIGNED, 0, when 1 the upper accumulate beat is sign-extended from S[143]; when 0 it is zero-extended.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  S and in_mode are valid this cycle.
- in_ready  output  1  unpacker accepts a word this cycle.
- S  input  144  packed result word.
- in_mode  input  1  1 = pass-through packing, 0 = accumulate packing.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  36  current beat.
- out_beat  output  2  index of the current beat within its word.
- out_last  output  1  current beat is the final beat of its word.
- words_done  output  CNT_W  count of fully drained words.

Behaviour:
- State machine: IDLE, SEND.
- On reset: state IDLE, holding register 0, beat counter 0, out_valid 0, out_data 0, out_beat 0, out_last 0, words_done 0.
- Reset mid-operation discards the held word. Beats already transferred stand; the remaining beats are never emitted.
- in_ready = (state==IDLE) OR (out_valid AND out_ready AND out_last). This combinational out_ready->in_ready path is intended and allows back-to-back words with no bubble.
- Accept = in_valid AND in_ready.
  - On accept: capture S and in_mode into the holding register; beat counter <= 0; state <= SEND.
  - Latency: a word accepted at edge N presents beat 0 with out_valid=1 from edge N onward, i.e. in the cycle after acceptance.
- In SEND, out_valid=1. out_data, out_beat and out_last depend only on registered state, so they stay stable while out_valid=1 and out_ready=0.
- Pass-through beats:
  - beat 0 = S[35:0]
  - beat 1 = S[71:36]
  - beat 2 = S[107:72]
  - beat 3 = S[143:108], with out_last=1
- Accumulate beats:
  - beat 0 = S[135:100]
  - beat 1 = {28 copies of ext, S[143:136]}, with out_last=1; ext = S[143] if ACC_SIGNED else 0
  - S[99:0] is ignored.
- Transfer = out_valid AND out_ready.
  - Non-last beat: beat counter increments.
  - Last beat: words_done increments, wrapping at 2^CNT_W to 0.
  - Last beat with a simultaneous accept: the new word loads, beat counter <= 0, state stays SEND.
  - Last beat without an accept: state <= IDLE, out_valid <= 0.
- Throughput: 1 beat per cycle when out_ready is held high; 4 cycles per pass-through word, 2 per accumulate word.
- in_mode is sampled only on accept. Changes to in_mode or S while no word is being accepted have no effect.

Test Plan:
- Reset, then pass-through word S = {36'hDDDDDDDDD, 36'hCCCCCCCCC, 36'hBBBBBBBBB, 36'hAAAAAAAAA} with in_mode=1 and out_ready=1 -> beats AAAAAAAAA, BBBBBBBBB, CCCCCCCCC, DDDDDDDDD on 4 consecutive cycles; out_beat 0..3; out_last only on beat 3; words_done=1.
- Accumulate word with S[143:100] = 44'hF12_3456_789A, S[99:0] = random, in_mode=0, ACC_SIGNED=0 -> beat 0 = 36'h2_3456_789A; beat 1 = 36'h0_0000_00F1 with out_last=1. With ACC_SIGNED=1, beat 1 = 36'hF_FFFF_FFF1.
- Two words offered back-to-back with out_ready=1 -> in_ready=1 in the cycle of the first word's last beat; second word's beat 0 appears the next cycle with no gap; words_done=2.
- out_ready toggled 1,0,0,1,... during a pass-through word -> no beat is lost or duplicated; out_data and out_beat are held while out_ready=0; in_ready=0 until the last beat transfers.
- reset asserted during beat 2 of a pass-through word -> next cycle out_valid=0, in_ready=1, words_done=0; the following word drains normally from beat 0.
- Preload words_done to 16'hFFFF by draining 65535 words (or force it), then drain one more word -> words_done wraps to 0.
